// File: rtl/upmux_nto1_arb.sv
// upmux_nto1_arb: merges N client flit channels into one hub input port.
// Each accepted flit records its source channel in an in-order queue. Every
// hub credit pulse pops that queue and returns a one-cycle credit to the
// client that sent the oldest outstanding flit.
// Build option: define UPMUX_RR_EN for round-robin arbitration; leave it
// undefined for fixed priority (lowest requesting index wins).
module upmux_nto1_arb #(
  parameter int N     = 4,
  parameter int DW    = 20,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] c_data,
  input  logic [N-1:0]    c_vld,
  output logic [N-1:0]    c_gnt,
  output logic [N-1:0]    c_cred,
  output logic [DW-1:0]   hub_in_data,
  output logic            hub_in_valid,
  input  logic            hub_co,
  output logic            cred_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Source queue and its bookkeeping
  logic [IW-1:0] srcq_q [DEPTH];
  logic [IW-1:0] srcq_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] pend_q, pend_d;

  // Output registers
  logic [DW-1:0] hub_data_q, hub_data_d;
  logic          hub_valid_q, hub_valid_d;
  logic [N-1:0]  cred_q, cred_d;
  logic          err_q, err_d;

`ifdef UPMUX_RR_EN
  // Last granted index; search starts one past it
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Combinational arbitration signals
  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          underflow_s;
  logic          accept_s;
  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic [IW-1:0] cand_s;
  logic [N-1:0]  gnt_s;

  // Occupancy decode and pop/underflow qualification on pre-edge state
  always_comb begin
    full_s      = (pend_q == DEPTH_C);
    empty_s     = (pend_q == {CW{1'b0}});
    pop_s       = hub_co && !empty_s;
    underflow_s = hub_co && empty_s;
  end

  // Arbiter: scan requesters in priority order and take the first one found
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
`ifdef UPMUX_RR_EN
      cand_s = IW'((int'(rr_ptr_q) + 1 + k) % N);
`else
      cand_s = IW'(k);
`endif
      if (!win_found_s && c_vld[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant: suppressed in reset and while the source queue is full (no hub_co bypass)
  always_comb begin
    gnt_s    = {N{1'b0}};
    accept_s = 1'b0;
    if (!rst && !full_s && win_found_s) begin
      gnt_s[win_idx_s] = 1'b1;
      accept_s         = 1'b1;
    end else begin
      gnt_s    = {N{1'b0}};
      accept_s = 1'b0;
    end
  end

  assign c_gnt = gnt_s;

  // Next state: accept pushes the source, hub credit pops it, strobes default low
  always_comb begin
    srcq_d      = srcq_q;
    head_d      = head_q;
    tail_d      = tail_q;
    hub_data_d  = hub_data_q;
    hub_valid_d = 1'b0;
    cred_d      = {N{1'b0}};
    err_d       = err_q;
`ifdef UPMUX_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    if (accept_s) begin
      hub_data_d     = c_data[int'(win_idx_s)*DW +: DW];
      hub_valid_d    = 1'b1;
      srcq_d[tail_q] = win_idx_s;
      tail_d         = tail_q + PW'(1);
`ifdef UPMUX_RR_EN
      rr_ptr_d       = win_idx_s;
`endif
    end else begin
      hub_valid_d = 1'b0;
    end

    if (pop_s) begin
      cred_d[srcq_q[head_q]] = 1'b1;
      head_d                 = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    if (underflow_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case ({accept_s, pop_s})
      2'b10:   pend_d = pend_q + CW'(1);
      2'b01:   pend_d = pend_q - CW'(1);
      default: pend_d = pend_q;
    endcase
  end

  // State registers with synchronous reset; reset discards queued sources
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        srcq_q[i] <= {IW{1'b0}};
      end
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      pend_q      <= {CW{1'b0}};
      hub_data_q  <= {DW{1'b0}};
      hub_valid_q <= 1'b0;
      cred_q      <= {N{1'b0}};
      err_q       <= 1'b0;
`ifdef UPMUX_RR_EN
      rr_ptr_q    <= IW'(N - 1);
`endif
    end else begin
      srcq_q      <= srcq_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pend_q      <= pend_d;
      hub_data_q  <= hub_data_d;
      hub_valid_q <= hub_valid_d;
      cred_q      <= cred_d;
      err_q       <= err_d;
`ifdef UPMUX_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign hub_in_data  = hub_data_q;
  assign hub_in_valid = hub_valid_q;
  assign c_cred       = cred_q;
  assign cred_err     = err_q;

endmodule

// File: tb/tb_upmux_nto1_arb.sv
// Self-checking bench for upmux_nto1_arb: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all compared every cycle against
// a queue-based reference model. Honours UPMUX_RR_EN for the arbitration mode.
module tb_upmux_nto1_arb;

  localparam int N     = 4;
  localparam int DW    = 20;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] c_data;
  logic [N-1:0]    c_vld;
  logic [N-1:0]    c_gnt;
  logic [N-1:0]    c_cred;
  logic [DW-1:0]   hub_in_data;
  logic            hub_in_valid;
  logic            hub_co;
  logic            cred_err;

  upmux_nto1_arb #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .c_data(c_data), .c_vld(c_vld), .c_gnt(c_gnt),
    .c_cred(c_cred), .hub_in_data(hub_in_data), .hub_in_valid(hub_in_valid),
    .hub_co(hub_co), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding sources in hub order plus expected registered outputs
  int            srcq[$];
  logic          m_hv;
  logic [DW-1:0] m_hd;
  logic [N-1:0]  m_cred;
  logic          m_err;
`ifdef UPMUX_RR_EN
  int            m_ptr;
`endif
  logic [N-1:0]  last_gnt;

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] dat;
    logic          hco;
    logic [N-1:0]  gnt;
    logic          hv;
    logic [DW-1:0] hd;
    logic [N-1:0]  cred;
    logic          err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = N'(1) << i;
  endfunction

  // Bus with channel i carrying base + i*inc
  function automatic logic [N*DW-1:0] bus(input logic [DW-1:0] base, input int inc);
    bus = '0;
    for (int i = 0; i < N; i++) bus[i*DW +: DW] = base + DW'(i * inc);
  endfunction

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input logic r);
    model_gnt = '0;
    if (!r && srcq.size() < DEPTH && v != '0) begin
`ifdef UPMUX_RR_EN
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (v[c] && model_gnt == '0) model_gnt = oh(c);
      end
`else
      for (int c = 0; c < N; c++) begin
        if (v[c] && model_gnt == '0) model_gnt = oh(c);
      end
`endif
    end
  endfunction

  // One clock cycle: drive, check grant before the edge, advance model, check after the edge
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic h, input logic r);
    logic [N-1:0] g;
    c_vld = v; c_data = d; hub_co = h; rst = r;
    #2;
    g = model_gnt(v, r);
    last_gnt = c_gnt;
    chk("c_gnt", c_gnt, g);
    if (r) begin
      srcq.delete();
      m_hv = 1'b0; m_hd = '0; m_cred = '0; m_err = 1'b0;
`ifdef UPMUX_RR_EN
      m_ptr = N - 1;
`endif
    end else begin
      m_hv = 1'b0;
      m_cred = '0;
      if (h) begin
        if (srcq.size() > 0) m_cred = oh(srcq.pop_front());
        else m_err = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_hd = d[i*DW +: DW];
          m_hv = 1'b1;
          srcq.push_back(i);
`ifdef UPMUX_RR_EN
          m_ptr = i;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    chk("hub_in_valid", hub_in_valid, m_hv);
    chk("hub_in_data", hub_in_data, m_hd);
    chk("c_cred", c_cred, m_cred);
    chk("cred_err", cred_err, m_err);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    int              n_acc;
    int              exp_g[5];
    int              exp_c[4];

    // Directed table; only one requester at a time so both arbiter builds agree
    tbl[0] = '{4'b0100, 20'hABCDE, 1'b0, 4'b0100, 1'b1, 20'hABCDE, 4'b0000, 1'b0};
    tbl[1] = '{4'b0000, 20'h00000, 1'b0, 4'b0000, 1'b0, 20'hABCDE, 4'b0000, 1'b0};
    tbl[2] = '{4'b0000, 20'h00000, 1'b1, 4'b0000, 1'b0, 20'hABCDE, 4'b0100, 1'b0};
    tbl[3] = '{4'b0000, 20'h00000, 1'b1, 4'b0000, 1'b0, 20'hABCDE, 4'b0000, 1'b1};
    tbl[4] = '{4'b0001, 20'h12345, 1'b0, 4'b0001, 1'b1, 20'h12345, 4'b0000, 1'b1};
    tbl[5] = '{4'b1000, 20'h54321, 1'b1, 4'b1000, 1'b1, 20'h54321, 4'b0001, 1'b1};
    tbl[6] = '{4'b0000, 20'h00000, 1'b1, 4'b0000, 1'b0, 20'h54321, 4'b1000, 1'b1};
    tbl[7] = '{4'b0000, 20'h00000, 1'b0, 4'b0000, 1'b0, 20'h54321, 4'b0000, 1'b1};
    tbl[8] = '{4'b0010, 20'h0F0F0, 1'b1, 4'b0010, 1'b1, 20'h0F0F0, 4'b0000, 1'b1};
    tbl[9] = '{4'b0000, 20'h00000, 1'b1, 4'b0000, 1'b0, 20'h0F0F0, 4'b0010, 1'b1};

    // Reset state
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("rst_gnt", last_gnt, 32'd0);
    chk("rst_valid", hub_in_valid, 32'd0);
    chk("rst_data", hub_in_data, 32'd0);
    chk("rst_cred", c_cred, 32'd0);
    chk("rst_err", cred_err, 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].vld, bus(tbl[i].dat, 0), tbl[i].hco, 1'b0);
      chk($sformatf("tbl%0d_gnt", i), last_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_valid", i), hub_in_valid, tbl[i].hv);
      chk($sformatf("tbl%0d_data", i), hub_in_data, tbl[i].hd);
      chk($sformatf("tbl%0d_cred", i), c_cred, tbl[i].cred);
      chk($sformatf("tbl%0d_err", i), cred_err, tbl[i].err);
    end

    // Contention and credit order
    step('0, '0, 1'b0, 1'b1);
`ifdef UPMUX_RR_EN
    exp_g = '{0, 1, 2, 3, 0};
    exp_c = '{0, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, bus(20'h10000, 1), 1'b0, 1'b0);
      chk($sformatf("rr_gnt%0d", i), last_gnt, oh(exp_g[i]));
    end
`else
    exp_g = '{0, 0, 0, 3, 3};
    exp_c = '{0, 0, 0, 3};
    for (int i = 0; i < 4; i++) begin
      step((i < 3) ? 4'b1001 : 4'b1000, bus(20'h10000, 1), 1'b0, 1'b0);
      chk($sformatf("fp_gnt%0d", i), last_gnt, oh(exp_g[i]));
    end
`endif
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b1, 1'b0);
      chk($sformatf("order_cred%0d", i), c_cred, oh(exp_c[i]));
    end

    // Full: eight accepts, then grants stop; a credit frees one slot the next cycle
    step('0, '0, 1'b0, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, bus(20'h20000, 3), 1'b0, 1'b0);
      if (last_gnt != '0) n_acc++;
    end
    chk("full_accepts", n_acc, 32'd8);
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, bus(20'h20000, 3), 1'b0, 1'b0);
      chk("full_gnt", last_gnt, 32'd0);
    end
    step(4'b1111, bus(20'h20000, 3), 1'b1, 1'b0);
    chk("full_nobypass_gnt", last_gnt, 32'd0);
    chk("full_first_cred", c_cred, 32'd1);
    step(4'b1111, bus(20'h20000, 3), 1'b0, 1'b0);
    chk("full_resume", (last_gnt != '0), 32'd1);

    // Simultaneous accept and pop at three outstanding, long enough for both pointers to wrap
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(oh(i % N), bus(20'h30000, 5), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(oh((3 + i) % N), bus(20'h31000, 7), 1'b1, 1'b0);
      chk("sim_gnt", last_gnt, oh((3 + i) % N));
      chk("sim_cred", c_cred, oh(i % N));
    end
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      step(4'b0001, bus(20'h32000, 1), 1'b0, 1'b0);
      if (last_gnt != '0) n_acc++;
    end
    chk("sim_room_left", n_acc, 32'd5);

    // Reset mid-stream with five outstanding and the error flag set
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b1, 1'b0);
    chk("err_set", cred_err, 32'd1);
    chk("err_nocred", c_cred, 32'd0);
    step('0, '0, 1'b0, 1'b0);
    chk("err_sticky", cred_err, 32'd1);
    for (int i = 0; i < 5; i++) step(oh((i + 1) % N), bus(20'h40000, 9), 1'b0, 1'b0);
    step(4'b1111, bus(20'h41000, 1), 1'b1, 1'b1);
    chk("mid_rst_gnt", last_gnt, 32'd0);
    chk("mid_rst_valid", hub_in_valid, 32'd0);
    chk("mid_rst_data", hub_in_data, 32'd0);
    chk("mid_rst_cred", c_cred, 32'd0);
    chk("mid_rst_err", cred_err, 32'd0);
    step('0, '0, 1'b1, 1'b0);
    chk("mid_rst_discard_cred", c_cred, 32'd0);
    chk("mid_rst_discard_err", cred_err, 32'd1);

    // Randomized traffic; clients hold each flit until it is granted
    step('0, '0, 1'b0, 1'b1);
    rv = '0;
    rd = '0;
    for (int t = 0; t < 2000; t++) begin
      logic r;
      logic h;
      r = ($urandom_range(0, 299) == 0);
      h = ($urandom_range(0, 99) < (((t / 250) % 2) != 0 ? 85 : 30));
      step(rv, rd, h, r);
      rv = rv & ~last_gnt;
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom_range(0, 1) == 1)) begin
          rv[i] = 1'b1;
          rd[i*DW +: DW] = DW'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
